// File: rtl/dds_rom_addr_gen.sv
// NCO wrapper around a registered quarter-wave sine ROM: phase accumulator,
// quarter-wave address folding, and quadrant sign restoration of the ROM output.
module dds_rom_addr_gen #(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   sync_clr,
    input  logic                   fcw_load,
    input  logic [PHASE_WIDTH-1:0] fcw_in,
    input  logic [PHASE_WIDTH-1:0] phase_ofs,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_q,
    output logic [DATA_WIDTH:0]    sample_out,
    output logic                   sample_valid
);

    localparam int LSB = PHASE_WIDTH - 2 - ADDR_WIDTH;

    logic [PHASE_WIDTH-1:0] acc;
    logic [PHASE_WIDTH-1:0] fcw;
    logic [1:0]             quad;
    logic [ADDR_WIDTH-1:0]  idx;
    logic [LSB-1:0]         p_unused;
    logic                   v1, s1, v2, s2;

    // Truncated fractional phase bits are intentionally dropped.
    assign {quad, idx, p_unused} = acc + phase_ofs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            rom_addr <= '0;
            v1       <= 1'b0;
            s1       <= 1'b0;
        end else if (sync_clr) begin
            acc <= '0;
            v1  <= 1'b0;
        end else if (en) begin
            rom_addr <= quad[0] ? ~idx : idx;
            v1       <= 1'b1;
            s1       <= quad[1];
            acc      <= acc + fcw;
        end else begin
            v1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcw <= '0;
        end else if (fcw_load) begin
            fcw <= fcw_in;
        end
    end

    // The ROM reads every cycle, so the valid/sign pipe shifts regardless of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2           <= 1'b0;
            s2           <= 1'b0;
            sample_valid <= 1'b0;
            sample_out   <= '0;
        end else begin
            v2           <= v1;
            s2           <= s1;
            sample_valid <= v2;
            if (v2) begin
                sample_out <= s2 ? -{1'b0, rom_q} : {1'b0, rom_q};
            end
        end
    end

endmodule

// File: tb/tb_dds_rom_addr_gen.sv
// Scoreboard bench for dds_rom_addr_gen; the ROM model returns its registered address
// so every expected sample is the signed folded address.
module tb_dds_rom_addr_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        sync_clr = 1'b0;
    logic        fcw_load = 1'b0;
    logic [31:0] fcw_in = '0;
    logic [31:0] phase_ofs = '0;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_q = '0;
    logic [8:0]  sample_out;
    logic        sample_valid;

    dds_rom_addr_gen #(
        .PHASE_WIDTH(32),
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sync_clr    (sync_clr),
        .fcw_load    (fcw_load),
        .fcw_in      (fcw_in),
        .phase_ofs   (phase_ofs),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .sample_out  (sample_out),
        .sample_valid(sample_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom_addr;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [8:0]  smp;
        int unsigned edge_no;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_pass   = 0;

    bit [31:0] m_acc  = '0;
    bit [31:0] m_fcw  = '0;
    int        m_addr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Monitor: pops the oldest expected sample whenever the DUT presents one.
    always @(negedge clk) begin
        if (rst_n && sample_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid: got sample %0h with empty scoreboard (t=%0t)",
                         sample_out, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sample_out", {23'd0, sample_out}, {23'd0, e.smp});
                chk("latency", edge_cnt, e.edge_no + 2);
            end
        end
    end

    task automatic model_reset();
        m_acc  = '0;
        m_fcw  = '0;
        m_addr = 0;
        q.delete();
    endtask

    task automatic step(input bit e, input bit c, input bit l,
                        input logic [31:0] f, input logic [31:0] o);
        bit [31:0] p;
        int        quad, idx, s;
        exp_t      it;
        @(negedge clk);
        en = e; sync_clr = c; fcw_load = l; fcw_in = f; phase_ofs = o;
        @(posedge clk);
        #1;
        p = m_acc + o;
        if (c) begin
            m_acc = '0;
        end else if (e) begin
            quad   = int'(p >> 30);
            idx    = int'((p >> 22) & 32'hFF);
            m_addr = (quad % 2 == 1) ? 255 - idx : idx;
            s      = (quad >= 2) ? -m_addr : m_addr;
            it.smp     = s[8:0];
            it.edge_no = edge_cnt;
            q.push_back(it);
            m_acc = m_acc + m_fcw;
        end
        if (l) m_fcw = f;
        chk("rom_addr", {24'd0, rom_addr}, m_addr);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rom_addr", {24'd0, rom_addr}, 32'd0);
        chk("reset_valid", {31'd0, sample_valid}, 32'd0);
        chk("reset_sample", {23'd0, sample_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full wave: four quadrants plus wrap
        step(1'b0, 1'b0, 1'b1, 32'h0040_0000, '0);
        for (int i = 0; i < 1030; i++) step(1'b1, 1'b0, 1'b0, '0, '0);

        // fcw change coincident with en: old step once more, then the new one
        step(1'b1, 1'b0, 1'b1, 32'h0080_0000, '0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0, '0);

        // en gaps hold the accumulator
        step(1'b0, 1'b1, 1'b1, 32'h0040_0000, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0);

        // Quadrant peaks from phase offset alone
        step(1'b0, 1'b1, 1'b1, 32'h0000_0000, '0);
        step(1'b1, 1'b0, 1'b0, '0, 32'h4000_0000);
        chk("peak_pos_addr", {24'd0, rom_addr}, 32'd255);
        step(1'b1, 1'b0, 1'b0, '0, 32'hC000_0000);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        #2;
        chk("peak_neg_sample", {23'd0, sample_out}, 32'h101);

        // sync_clr then resume from acc=0
        step(1'b0, 1'b0, 1'b1, 32'h0123_4567, '0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0, 32'h1000_0000);
        step(1'b1, 1'b1, 1'b0, '0, 32'h1000_0000);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, 32'h1000_0000);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) == 0, $urandom, $urandom);
        end

        // Asynchronous reset between edges with reads in flight
        step(1'b1, 1'b0, 1'b1, 32'h0357_0000, '0);
        step(1'b1, 1'b0, 1'b0, '0, 32'h8000_0000);
        step(1'b1, 1'b0, 1'b0, '0, 32'h8000_0000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, sample_valid}, 32'd0);
        chk("async_rst_sample", {23'd0, sample_out}, 32'd0);
        chk("async_rst_addr", {24'd0, rom_addr}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b1, 32'h0100_0000, '0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, '0, $urandom);

        // Drain
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
        chk("scoreboard_empty", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
